// File: rtl/cobi_array_model.sv
// rtl/cobi_array_model.sv - behavioural model of a coupled-oscillator weight array with sample scanchain
module cobi_array_model #(
  parameter int ADDR_W        = 6,
  parameter int WEIGHT_W      = 6,
  parameter int SCAN_LEN      = 504,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                i_CLK,
  input  logic                i_RST_N,
  input  logic [ADDR_W-1:0]   i_ROW_ADDR,
  input  logic [ADDR_W-1:0]   i_COL_ADDR,
  input  logic [WEIGHT_W-1:0] i_WEIGHT,
  input  logic                i_WEIGHT_WE,
  output logic [WEIGHT_W-1:0] o_WEIGHT_RD,
  input  logic                i_ROSC_EN,
  input  logic                i_START,
  output logic                o_BUSY,
  output logic                o_DONE,
  input  logic                i_SHIFT,
  input  logic                i_SCAN_IN,
  output logic                o_SCAN_DOUT,
  output logic                o_SCAN_VALID
);

  localparam int FLAT_W = 2 * ADDR_W;
  localparam int NUM_W  = 1 << FLAT_W;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W  = $clog2(SCAN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [WEIGHT_W-1:0]  weights_q [NUM_W];
  logic [WEIGHT_W-1:0]  rd_q;
  logic [SCAN_LEN-1:0]  chain_q, chain_d;
  logic [SCAN_LEN-1:0]  cap_bits;
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy;
  logic                 capture_en;
  logic [FLAT_W-1:0]    flat_idx;

  // Row address forms the upper half of the flat weight index.
  assign flat_idx = {i_ROW_ADDR, i_COL_ADDR};

  // FSM state register; reset aborts any sample in flight.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: oscillator must stay enabled for the whole settle window.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_START && i_ROSC_EN) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!i_ROSC_EN) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers settle and capture, capture_en marks the capture cycle.
  always_comb begin
    busy       = 1'b0;
    capture_en = 1'b0;
    unique case (state_q)
      S_IDLE:    busy = 1'b0;
      S_SETTLE:  busy = 1'b1;
      S_CAPTURE: begin
        busy       = 1'b1;
        capture_en = 1'b1;
      end
      default:   busy = 1'b0;
    endcase
  end

  // Settle counter runs only while in SETTLE and clears otherwise.
  always_comb begin
    settle_cnt_d = '0;
    if (state_q == S_SETTLE) settle_cnt_d = settle_cnt_q + SET_W'(1);
  end

  // Settle counter register.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      settle_cnt_q <= '0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Weight storage: writes frozen during a sample; readback register samples pre-write value.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int i = 0; i < NUM_W; i++) weights_q[i] <= '0;
      rd_q <= '0;
    end else begin
      rd_q <= weights_q[flat_idx];
      if (i_WEIGHT_WE && !busy) weights_q[flat_idx] <= i_WEIGHT;
    end
  end

  // Capture image: bit 0 of each of the first SCAN_LEN weights in flat order.
  always_comb begin
    cap_bits = '0;
    for (int i = 0; i < SCAN_LEN; i++) cap_bits[i] = weights_q[FLAT_W'(i)][0];
  end

  // Chain next-state: capture has priority; shifting is blocked while busy.
  always_comb begin
    chain_d     = chain_q;
    shift_cnt_d = shift_cnt_q;
    valid_d     = valid_q;
    done_d      = capture_en;
    if (capture_en) begin
      chain_d     = cap_bits;
      shift_cnt_d = '0;
      valid_d     = 1'b1;
    end else if (i_SHIFT && !busy) begin
      for (int i = 0; i < SCAN_LEN - 1; i++) chain_d[i] = chain_q[i+1];
      chain_d[SCAN_LEN-1] = i_SCAN_IN;
      if (shift_cnt_q != CNT_W'(SCAN_LEN)) begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
        if (shift_cnt_q == CNT_W'(SCAN_LEN - 1)) valid_d = 1'b0;
      end
    end
  end

  // Chain, shift count, valid flag and done pulse registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      chain_q     <= '0;
      shift_cnt_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      shift_cnt_q <= shift_cnt_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign o_WEIGHT_RD  = rd_q;
  assign o_BUSY       = busy;
  assign o_DONE       = done_q;
  assign o_SCAN_DOUT  = chain_q[0];
  assign o_SCAN_VALID = valid_q;

endmodule

// File: tb/tb_cobi_array_model.sv
// tb/tb_cobi_array_model.sv - scoreboard testbench for cobi_array_model
module tb_cobi_array_model;

  localparam int ADDR_W   = 6;
  localparam int WEIGHT_W = 6;
  localparam int SCAN_LEN = 504;
  localparam int SETTLE   = 16;
  localparam int NW       = 1 << (2 * ADDR_W);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ADDR_W-1:0]   row = '0, col = '0;
  logic [WEIGHT_W-1:0] wdata = '0;
  logic                we = 1'b0, rosc = 1'b0, start = 1'b0, shift = 1'b0, scan_in = 1'b0;
  logic [WEIGHT_W-1:0] rd;
  logic                busy, done, dout, valid;

  cobi_array_model #(
    .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .SCAN_LEN(SCAN_LEN), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_ROW_ADDR(row), .i_COL_ADDR(col),
    .i_WEIGHT(wdata), .i_WEIGHT_WE(we), .o_WEIGHT_RD(rd), .i_ROSC_EN(rosc),
    .i_START(start), .o_BUSY(busy), .o_DONE(done), .i_SHIFT(shift),
    .i_SCAN_IN(scan_in), .o_SCAN_DOUT(dout), .o_SCAN_VALID(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WEIGHT_W-1:0] rd;
    logic busy;
    logic done;
    logic valid;
    logic dout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: weights array, chain as a bit queue, sample as a countdown.
  bit [WEIGHT_W-1:0] m_w [NW];
  bit                m_chain[$];
  int                m_busy_left;
  int                m_shifts;
  bit                m_valid, m_done;
  bit [WEIGHT_W-1:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_w[i]) m_w[i] = '0;
    m_chain.delete();
    repeat (SCAN_LEN) m_chain.push_back(1'b0);
    m_busy_left = 0;
    m_shifts    = 0;
    m_valid     = 1'b0;
    m_done      = 1'b0;
    m_rd        = '0;
  endfunction

  // Advance the model across the next rising edge and queue the expected outputs.
  task automatic model_step();
    int   idx;
    bit   idle;
    bit   cap;
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else begin
      idx  = int'({row, col});
      idle = (m_busy_left == 0);
      cap  = 1'b0;
      m_rd = m_w[idx];
      if (idle && we) m_w[idx] = wdata;
      if (idle && shift) begin
        void'(m_chain.pop_front());
        m_chain.push_back(scan_in);
        if (m_shifts < SCAN_LEN) begin
          m_shifts++;
          if (m_shifts == SCAN_LEN) m_valid = 1'b0;
        end
      end
      if (m_busy_left == 1) begin
        for (int i = 0; i < SCAN_LEN; i++) m_chain[i] = m_w[i][0];
        m_valid     = 1'b1;
        m_shifts    = 0;
        m_busy_left = 0;
        cap         = 1'b1;
      end else if (m_busy_left > 1) begin
        if (!rosc) m_busy_left = 0;
        else m_busy_left--;
      end else if (start && rosc) begin
        m_busy_left = SETTLE + 1;
      end
      m_done = cap;
    end
    e.rd    = m_rd;
    e.busy  = (m_busy_left > 0);
    e.done  = m_done;
    e.valid = m_valid;
    e.dout  = m_chain[0];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs just after every rising edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd",    32'(rd),    32'(e.rd));
        chk("busy",  32'(busy),  32'(e.busy));
        chk("done",  32'(done),  32'(e.done));
        chk("valid", 32'(valid), 32'(e.valid));
        chk("dout",  32'(dout),  32'(e.dout));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("reset_rd",    32'(rd), 0);
    chk("reset_busy",  32'(busy), 0);
    chk("reset_done",  32'(done), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_dout",  32'(dout), 0);
    rst_n = 1'b1;
    row = 0; col = 0;
    tick();
    chk("rd_w00_reset", 32'(rd), 0);

    // Abort: drop the oscillator enable in settle cycle 8.
    rosc = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort_busy_before", 32'(busy), 1);
    rosc = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    rosc = 1'b1;
    repeat (12) begin
      tick();
      chk("abort_no_done", 32'(done), 0);
    end

    // Write two weights, read one back, take a sample and shift to bits 5 and 6.
    row = 0; col = 5; wdata = 6'h01; we = 1'b1;
    tick();
    col = 6; wdata = 6'h3E;
    tick();
    we = 1'b0; col = 5;
    tick();
    chk("rd_w05", 32'(rd), 32'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("sample_busy_c16", 32'(busy), 1);
    chk("sample_done_c16", 32'(done), 0);
    tick();
    chk("sample_done_c17", 32'(done), 1);
    chk("sample_valid", 32'(valid), 1);
    shift = 1'b1; scan_in = 1'b0;
    repeat (5) tick();
    chk("scan_bit5", 32'(dout), 1);
    tick();
    chk("scan_bit6", 32'(dout), 0);
    shift = 1'b0;
    tick();

    // Writes, starts and shifts while busy are all ignored.
    row = 0; col = 0;
    start = 1'b1;
    tick();
    we = 1'b1; wdata = 6'h3F; shift = 1'b1; scan_in = 1'b1;
    repeat (10) tick();
    we = 1'b0; start = 1'b0; shift = 1'b0;
    repeat (7) tick();
    chk("busy_done", 32'(done), 1);
    chk("busy_chain_bit0", 32'(dout), 0);
    tick();
    chk("busy_rd_w00", 32'(rd), 0);
    chk("busy_no_resample", 32'(busy), 0);
    chk("busy_single_done", 32'(done), 0);

    // Full chain drain with ones shifted in.
    shift = 1'b1; scan_in = 1'b1;
    repeat (SCAN_LEN - 1) tick();
    chk("drain_valid_503", 32'(valid), 1);
    tick();
    chk("drain_valid_504", 32'(valid), 0);
    chk("drain_dout", 32'(dout), 1);
    shift = 1'b0;
    tick();

    // Reset in settle cycle 5, then a fresh sample completes.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_now", 32'(busy), 0);
    chk("rst_done_now", 32'(done), 0);
    tick();
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SETTLE + 1) tick();
    chk("post_rst_done", 32'(done), 1);

    // Randomized traffic concentrated on the scanned rows.
    repeat (3000) begin
      row     = ADDR_W'($urandom_range(0, 8));
      col     = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wdata   = WEIGHT_W'($urandom);
      we      = ($urandom_range(0, 9) < 3);
      start   = ($urandom_range(0, 19) == 0);
      rosc    = ($urandom_range(0, 39) != 0);
      shift   = ($urandom_range(0, 9) < 4);
      scan_in = 1'($urandom);
      rst_n   = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1; we = 1'b0; start = 1'b0; shift = 1'b0; rosc = 1'b1;
    repeat (4) tick();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
